// File: rtl/d081_pkg.sv
// Shared defaults and the data word type for the d081 byte register bank.
package d081_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = 8'h00;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/d081_stage.sv
// One WIDTH-bit register with synchronous, active-high reset to RESET_VALUE.
module d081_stage
   import d081_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= RESET_VALUE;
      else       q <= d;
   end

endmodule

// File: rtl/d081.sv
// Byte register bank: STAGES cascaded registers, all cleared together by reset.
module d081
   import d081_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE),
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1) begin : g_bad_width
      $error("d081: WIDTH must be >= 1");
   end
   if (STAGES < 1) begin : g_bad_stages
      $error("d081: STAGES must be >= 1");
   end

   // chain[0] is the input; chain[k+1] is the output of stage k.
   logic [WIDTH-1:0] chain [STAGES+1];

   assign chain[0] = d;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      d081_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .d     (chain[k]),
         .q     (chain[k+1])
      );
   end

   assign q = chain[STAGES];

endmodule

// File: tb/tb_d081.sv
// Directed bench for d081: default single-stage bank and a 3-stage bank with reset value C3.
module tb_d081;
   import d081_pkg::*;

   logic  clk;
   logic  reset, reset3;
   word_t d, d3, q, q3;

   int compared = 0;
   int mismatched = 0;

   d081 dut (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q)
   );

   d081 #(
      .WIDTH       (8),
      .RESET_VALUE (8'hC3),
      .STAGES      (3)
   ) dut3 (
      .clk   (clk),
      .reset (reset3),
      .d     (d3),
      .q     (q3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t observed, input word_t expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic edge_then_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      word_t stream [4];
      stream[0] = 8'h01;
      stream[1] = 8'h80;
      stream[2] = 8'hFF;
      stream[3] = 8'h3C;

      reset  = 1'b0;
      d      = 8'h00;
      reset3 = 1'b1;
      d3     = 8'h00;

      // idle with d = 0 for 100 periods: q must be 00, never X, from edge 1
      for (int i = 0; i < 100; i++) begin
         edge_then_settle();
         check("idle_zero", q, 8'h00);
      end
      check("dut3_reset_value", q3, 8'hC3);

      // reset for two edges with A5 on d, then release
      @(negedge clk);
      reset = 1'b1;
      d     = 8'hA5;
      edge_then_settle();
      check("reset_edge1", q, 8'h00);
      edge_then_settle();
      check("reset_edge2", q, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      edge_then_settle();
      check("release_a5", q, 8'hA5);

      // successive values, each visible one edge later
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         d = stream[i];
         #1;
         check("no_comb_path", q, (i == 0) ? 8'hA5 : stream[i-1]);
         edge_then_settle();
         check("stream", q, stream[i]);
      end

      // glitch between edges: only the value stable at the edge is captured
      @(negedge clk);
      d = 8'h55;
      #1;
      check("glitch_hold", q, 8'h3C);
      #1;
      d = 8'hAA;
      edge_then_settle();
      check("glitch_capture", q, 8'hAA);

      // short reset pulse between edges has no effect
      @(negedge clk);
      d = 8'h77;
      edge_then_settle();
      check("load_77", q, 8'h77);
      #2;
      reset = 1'b1;
      #3;
      reset = 1'b0;
      #1;
      check("short_pulse_mid", q, 8'h77);
      edge_then_settle();
      check("short_pulse_after", q, 8'h77);
      @(negedge clk);
      reset = 1'b1;
      edge_then_settle();
      check("reset_across_edge", q, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      // three-stage bank: latency of three edges, reset value C3
      @(negedge clk);
      reset3 = 1'b0;
      d3     = 8'h10;
      edge_then_settle();
      check("s3_e1", q3, 8'hC3);
      @(negedge clk);
      d3 = 8'h20;
      edge_then_settle();
      check("s3_e2", q3, 8'hC3);
      @(negedge clk);
      d3 = 8'h30;
      edge_then_settle();
      check("s3_e3_first", q3, 8'h10);
      @(negedge clk);
      d3 = 8'h40;
      edge_then_settle();
      check("s3_e4_second", q3, 8'h20);

      // reset mid-stream: 30 and 40 are in flight and must never appear
      @(negedge clk);
      reset3 = 1'b1;
      edge_then_settle();
      check("s3_mid_reset", q3, 8'hC3);
      @(negedge clk);
      reset3 = 1'b0;
      d3     = 8'h50;
      edge_then_settle();
      check("s3_flush1", q3, 8'hC3);
      @(negedge clk);
      d3 = 8'h60;
      edge_then_settle();
      check("s3_flush2", q3, 8'hC3);
      @(negedge clk);
      d3 = 8'h70;
      edge_then_settle();
      check("s3_release_first", q3, 8'h50);
      edge_then_settle();
      check("s3_release_second", q3, 8'h60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
